// File: rtl/ram_16384x39_arb2.sv
// Round-robin two-port arbiter and sequencer for a single-port 16384x39 SRAM macro, 1-cycle read latency.
// Optional post-reset array clear under `RAM_MEM_CLEAR_EN; requesters hold REQ/payload until GNT.
module ram_16384x39_arb2 #(
  parameter int AW    = 14,
  parameter int DW    = 39,
  parameter int DEPTH = 16384
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADR,
  input  logic [DW-1:0] A_D,
  output logic          A_GNT,
  output logic          A_RVLD,
  output logic [DW-1:0] A_Q,
  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADR,
  input  logic [DW-1:0] B_D,
  output logic          B_GNT,
  output logic          B_RVLD,
  output logic [DW-1:0] B_Q,
  output logic [AW-1:0] RAM_ADR,
  output logic [DW-1:0] RAM_D,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_Q,
  output logic          BUSY
);

  if (DEPTH != (1 << AW)) begin : g_depth_chk
    $error("DEPTH must equal 2**AW");
  end

  logic          r_ptr;
  logic          r_a_rvld;
  logic          r_b_rvld;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_d;

  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_adr;
  logic          w_ok;
  logic          w_a_gnt;
  logic          w_b_gnt;
  logic [AW-1:0] w_ram_adr;
  logic [DW-1:0] w_ram_d;
  logic          w_ram_we;

`ifdef RAM_MEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_cnt == AW'(DEPTH - 1)) w_state_nxt = S_RUN;
  end

  // Clear writes are suppressed while RST is high so the macro sees no WE during reset.
  always_comb begin
    w_busy    = (r_state == S_CLEAR);
    w_clr_we  = (r_state == S_CLEAR) & ~RST;
    w_clr_adr = r_cnt;
  end
`else
  assign w_busy    = 1'b0;
  assign w_clr_we  = 1'b0;
  assign w_clr_adr = '0;
`endif

  assign w_ok    = ~RST & ~w_busy;
  assign w_a_gnt = w_ok & A_REQ & (~B_REQ | ~r_ptr);
  assign w_b_gnt = w_ok & B_REQ & (~A_REQ |  r_ptr);

  // Idle cycles replay the shadowed address/data so the macro inputs stay quiet.
  always_comb begin
    w_ram_adr = r_adr;
    w_ram_d   = r_d;
    w_ram_we  = 1'b0;
    if (w_clr_we) begin
      w_ram_adr = w_clr_adr;
      w_ram_d   = '0;
      w_ram_we  = 1'b1;
    end else if (w_a_gnt) begin
      w_ram_adr = A_ADR;
      w_ram_d   = A_D;
      w_ram_we  = A_WE;
    end else if (w_b_gnt) begin
      w_ram_adr = B_ADR;
      w_ram_d   = B_D;
      w_ram_we  = B_WE;
    end
  end

  always_ff @(posedge CLK) begin
    r_adr <= w_ram_adr;
    r_d   <= w_ram_d;
    if (RST) begin
      r_ptr    <= 1'b0;
      r_a_rvld <= 1'b0;
      r_b_rvld <= 1'b0;
    end else begin
      if (w_a_gnt)      r_ptr <= 1'b1;
      else if (w_b_gnt) r_ptr <= 1'b0;
      r_a_rvld <= w_a_gnt & ~A_WE;
      r_b_rvld <= w_b_gnt & ~B_WE;
    end
  end

  assign A_GNT   = w_a_gnt;
  assign B_GNT   = w_b_gnt;
  assign A_RVLD  = r_a_rvld;
  assign B_RVLD  = r_b_rvld;
  assign A_Q     = RAM_Q;
  assign B_Q     = RAM_Q;
  assign RAM_ADR = w_ram_adr;
  assign RAM_D   = w_ram_d;
  assign RAM_WE  = w_ram_we;
  assign BUSY    = w_busy;

endmodule

// File: tb/tb_ram_16384x39_arb2.sv
// Bench for ram_16384x39_arb2 with a behavioural SRAM macro and a round-robin reference model.
module tb_ram_16384x39_arb2;
  logic        CLK = 1'b0;
  logic        RST;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [13:0] A_ADR, B_ADR, RAM_ADR;
  logic [38:0] A_D, B_D, A_Q, B_Q, RAM_D, RAM_Q;
  logic        A_GNT, A_RVLD, B_GNT, B_RVLD, RAM_WE, BUSY;

  ram_16384x39_arb2 dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADR(A_ADR), .A_D(A_D),
    .A_GNT(A_GNT), .A_RVLD(A_RVLD), .A_Q(A_Q),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADR(B_ADR), .B_D(B_D),
    .B_GNT(B_GNT), .B_RVLD(B_RVLD), .B_Q(B_Q),
    .RAM_ADR(RAM_ADR), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Macro model: write-through on write, registered read otherwise.
  logic [38:0] mem [0:16383];
  always @(posedge CLK) begin
    if (RAM_WE) begin
      mem[RAM_ADR] <= RAM_D;
      RAM_Q        <= RAM_D;
    end else begin
      RAM_Q <= mem[RAM_ADR];
    end
  end

  typedef struct {
    bit          we;
    logic [13:0] adr;
    logic [38:0] d;
  } op_t;

  op_t         aq[$], bq[$];
  logic [38:0] qa[$], qb[$];
  logic [38:0] ref_mem [0:16383];
  bit          mptr;
  int          errs = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push_op(input bit port_b, input bit we, input logic [13:0] adr, input logic [38:0] d);
    op_t o;
    o.we = we; o.adr = adr; o.d = d;
    if (port_b) bq.push_back(o);
    else aq.push_back(o);
  endtask

  task automatic run_ops(input int budget);
    int n = 0;
    bit ga, gb, ea, eb;
    while ((aq.size() != 0 || bq.size() != 0) && n < budget) begin
      @(negedge CLK);
      RST   = 1'b0;
      A_REQ = (aq.size() != 0);
      if (A_REQ) begin A_WE = aq[0].we; A_ADR = aq[0].adr; A_D = aq[0].d; end
      B_REQ = (bq.size() != 0);
      if (B_REQ) begin B_WE = bq[0].we; B_ADR = bq[0].adr; B_D = bq[0].d; end
      #1;
      ga = A_REQ && (!B_REQ || !mptr);
      gb = B_REQ && (!A_REQ || mptr);
      chk("a_gnt", A_GNT, ga);
      chk("b_gnt", B_GNT, gb);
      chk("busy", BUSY, 0);
      ea = 1'b0; eb = 1'b0;
      if (ga) begin
        chk("ram_adr_a", RAM_ADR, A_ADR);
        chk("ram_we_a", RAM_WE, A_WE);
        if (A_WE) begin
          chk("ram_d_a", RAM_D, A_D);
          ref_mem[A_ADR] = A_D;
        end else begin
          qa.push_back(ref_mem[A_ADR]);
          ea = 1'b1;
        end
        mptr = 1'b1;
        void'(aq.pop_front());
      end else if (gb) begin
        chk("ram_adr_b", RAM_ADR, B_ADR);
        chk("ram_we_b", RAM_WE, B_WE);
        if (B_WE) begin
          chk("ram_d_b", RAM_D, B_D);
          ref_mem[B_ADR] = B_D;
        end else begin
          qb.push_back(ref_mem[B_ADR]);
          eb = 1'b1;
        end
        mptr = 1'b0;
        void'(bq.pop_front());
      end else begin
        chk("ram_we_idle", RAM_WE, 0);
      end
      @(posedge CLK);
      #1;
      chk("a_rvld", A_RVLD, ea);
      chk("b_rvld", B_RVLD, eb);
      if (ea && qa.size() != 0) chk("a_q", A_Q, qa.pop_front());
      if (eb && qb.size() != 0) chk("b_q", B_Q, qb.pop_front());
      n++;
    end
    chk("ops_left", aq.size() + bq.size(), 0);
  endtask

  task automatic idle_check();
    @(negedge CLK);
    A_REQ = 1'b0; B_REQ = 1'b0;
    #1;
    chk("idle_we", RAM_WE, 0);
    @(posedge CLK);
    #1;
    chk("idle_a_rvld", A_RVLD, 0);
    chk("idle_b_rvld", B_RVLD, 0);
  endtask

  // Leaves RST high; the next stimulus cycle releases it.
  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      RST = 1'b1; A_REQ = 1'b1; B_REQ = 1'b1; A_WE = 1'b0; B_WE = 1'b1;
      #1;
      chk("rst_a_gnt", A_GNT, 0);
      chk("rst_b_gnt", B_GNT, 0);
      chk("rst_ram_we", RAM_WE, 0);
      @(posedge CLK);
      #1;
      chk("rst_a_rvld", A_RVLD, 0);
      chk("rst_b_rvld", B_RVLD, 0);
`ifdef RAM_MEM_CLEAR_EN
      chk("rst_busy", BUSY, 1);
`else
      chk("rst_busy", BUSY, 0);
`endif
    end
    mptr = 1'b0;
    qa.delete(); qb.delete();
    A_REQ = 1'b0; B_REQ = 1'b0;
  endtask

`ifdef RAM_MEM_CLEAR_EN
  task automatic clear_seq();
    int cnt = 0;
    bit okw = 1'b1;
    @(negedge CLK);
    RST = 1'b0; A_REQ = 1'b1; A_WE = 1'b0; A_ADR = 14'h2A2A; B_REQ = 1'b0;
    #1;
    while (BUSY && cnt < 20000) begin
      if (!(RAM_WE && RAM_ADR == cnt[13:0] && RAM_D == 39'h0 && !A_GNT)) okw = 1'b0;
      cnt++;
      @(negedge CLK);
      #1;
    end
    chk("clear_cycles", cnt, 16384);
    chk("clear_writes", okw, 1);
    chk("clear_first_gnt", A_GNT, 1);
    for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
    mptr = 1'b1;
    @(posedge CLK);
    #1;
    chk("clear_rd_vld", A_RVLD, 1);
    chk("clear_rd_q", A_Q, ref_mem[14'h2A2A]);
    @(negedge CLK);
    A_REQ = 1'b0;
  endtask
`endif

  task automatic reset_all();
    do_reset();
`ifdef RAM_MEM_CLEAR_EN
    clear_seq();
`endif
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    RST = 1'b1; A_REQ = 1'b0; B_REQ = 1'b0; A_WE = 1'b0; B_WE = 1'b0;
    A_ADR = '0; B_ADR = '0; A_D = '0; B_D = '0;

    do_reset();
`ifndef RAM_MEM_CLEAR_EN
    // First cycle after release must already grant.
    push_op(1'b0, 1'b0, 14'h0005, '0);
    run_ops(4);
`else
    clear_seq();
`endif

    // Single write then read on A.
    push_op(1'b0, 1'b1, 14'h0010, 39'h12_3456_789A);
    push_op(1'b0, 1'b0, 14'h0010, '0);
    run_ops(10);
    idle_check();

    // Contention from a freshly reset pointer: A,B,A,B.
    for (int i = 0; i < 4; i++) push_op(1'b0, 1'b1, 14'h0100 + 14'(i), 39'h55_0000_0000 + 39'(i));
    run_ops(10);
    reset_all();
    push_op(1'b0, 1'b0, 14'h0100, '0);
    push_op(1'b0, 1'b0, 14'h0102, '0);
    push_op(1'b1, 1'b0, 14'h0101, '0);
    push_op(1'b1, 1'b0, 14'h0103, '0);
    run_ops(10);
    idle_check();

    // Top address write then read on B.
    push_op(1'b1, 1'b1, 14'h3FFF, 39'h7F_FFFF_FFFF);
    push_op(1'b1, 1'b0, 14'h3FFF, '0);
    run_ops(10);

    // Mixed random traffic on a small address window.
    for (int i = 0; i < 40; i++)
      push_op(1'(i % 2), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 7)), {7'($urandom), $urandom});
    run_ops(200);
    idle_check();

    // Reset right after a granted read; pointer must return to A.
    push_op(1'b0, 1'b0, 14'h0010, '0);
    run_ops(4);
    reset_all();
    push_op(1'b1, 1'b0, 14'h3FFF, '0);
    push_op(1'b0, 1'b0, 14'h0010, '0);
    run_ops(10);
    idle_check();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_16384x39_arb2.md
Name: ram_16384x39_arb2

Overview:
- Two-requester arbiter and sequencer for one single-port 16384x39 SRAM macro (ram_16384x39).
- Shares the macro's single ADR/D/WE/Q port between requester A and requester B with round-robin fairness.
- Returns read data with a valid strobe, and sequences an optional post-reset clear of the whole array.
- Sits directly between the SRAM macro and two client blocks.

Parameters:
- AW, 14, address width (16384 words)
- DW, 39, data width
- DEPTH, 16384, word count; used by the clear sequencer; must equal 2**AW

Ports:
- CLK  input  1  clock; all logic on posedge
- RST  input  1  synchronous, active-high reset
- A_REQ  input  1  requester A access request; held with A_WE/A_ADR/A_D stable until A_GNT
- A_WE  input  1  1 = write, 0 = read
- A_ADR  input  AW  address
- A_D  input  DW  write data
- A_GNT  output  1  access accepted this cycle (combinational)
- A_RVLD  output  1  A_Q holds read data of A's read granted in the previous cycle
- A_Q  output  DW  read data
- B_REQ, B_WE, B_ADR, B_D, B_GNT, B_RVLD, B_Q  same as the A ports, for requester B
- RAM_ADR  output  AW  to macro ADR
- RAM_D  output  DW  to macro D
- RAM_WE  output  1  to macro WE, active high
- RAM_Q  input  DW  from macro Q
- BUSY  output  1  clear sequence in progress; no grants while high

Behaviour:
- Reset state while RST=1 at posedge:
  - A_RVLD=B_RVLD=0, priority pointer=A, BUSY per the Optional Feature.
  - RAM_WE=0, A_GNT=B_GNT=0 combinationally while RST high.
- Grant (combinational, same cycle as REQ, only when not BUSY and not RST):
  - Only one port requesting: that port is granted.
  - Both requesting: the port named by the pointer is granted.
- Pointer update at posedge: after any grant, pointer := the non-granted port. With no grant, pointer is unchanged.
- RAM drive:
  - RAM_ADR/RAM_D/RAM_WE = granted port's ADR/D/WE.
  - No grant: RAM_WE=0, RAM_ADR/RAM_D hold their last driven values (registered shadow) to avoid macro toggling.
  - At most one macro access per cycle.
- Read latency 1:
  - Read granted in cycle N: X_RVLD=1 in cycle N+1 only.
  - X_Q = RAM_Q, passed through, valid only when X_RVLD=1.
  - Writes never produce RVLD.
  - A_Q/B_Q are don't-care when their RVLD=0; the macro drives X after a write.
- Back-to-back:
  - A requester may keep REQ high every cycle and is granted at most every other cycle under contention, every cycle without contention.
  - Read-after-write to the same address in consecutive cycles returns the new data.
- Ungranted requester keeps REQ and payload stable. Dropping REQ before GNT is permitted and simply withdraws the request.
- RST asserted mid-operation: pending RVLD is cancelled next edge, any in-flight clear restarts, pointer returns to A.

Optional Feature:
- Macro: RAM_MEM_CLEAR_EN
- Defined, FSM states:
  - CLEAR: entered on RST. Each cycle writes RAM_D=0, RAM_WE=1, RAM_ADR=counter; counter increments 0..DEPTH-1. BUSY=1, A_GNT=B_GNT=0.
  - After writing address DEPTH-1, go to RUN and set BUSY=0.
  - RUN: normal arbitration.
  - First grant is possible DEPTH+1 cycles after RST deasserts; RST during CLEAR restarts at address 0.
- Not defined: no counter or FSM; BUSY is tied 0; grants are possible in the first cycle after RST deasserts; RAM contents are not initialised.

Test Plan:
- Single read: write A ADR=0x0010 D=0x12_3456_789A, then read A ADR=0x0010 -> A_GNT each cycle, A_RVLD=1 one cycle after the read grant with A_Q=0x12_3456_789A; B_RVLD stays 0.
- Contention: A_REQ and B_REQ both held high for 4 reads, pointer=A after reset -> grant order A,B,A,B; each RVLD lags its grant by exactly 1 cycle; no cycle has two grants.
- Write then read in consecutive cycles: B writes ADR=0x3FFF D=0x7F_FFFF_FFFF, then B reads 0x3FFF -> B_Q=0x7F_FFFF_FFFF on B_RVLD; top address works without wrap error.
- Reset mid-read: RST asserted in the cycle after a granted read -> A_RVLD=0 the next cycle, pointer=A, RAM_WE=0 during RST.
- RAM_MEM_CLEAR_EN: RST then release -> BUSY=1 for exactly 16384 cycles, RAM_WE=1 with addresses 0..0x3FFF and D=0; an A_REQ held throughout is granted the first cycle BUSY=0; a read of 0x2A2A returns 0.
- Without RAM_MEM_CLEAR_EN: A_REQ high the cycle after RST release -> A_GNT=1 immediately and BUSY=0 throughout.
